// File: rtl/ps2_key_events_pkg.sv
// Shared types and constants for the PS/2 key-event front end.
package ps2_key_events_pkg;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_e;

  typedef enum logic [1:0] {
    D_BASE   = 2'b00,
    D_EXT    = 2'b01,
    D_BRK    = 2'b10,
    D_EXTBRK = 2'b11
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  // frame = {stop, parity, data[7:0]}; good when data+parity is odd and stop is 1
  function automatic logic frame_ok(input logic [9:0] frame);
    return (^frame[8:0]) & frame[9];
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// capture with parity/stop validation and an inactivity timeout.
module ps2_frame_rx
  import ps2_key_events_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_prev_q;
  logic          fe;
  logic          dat_s;

  rx_state_e     state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fe    = clk_prev_q & ~clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;

    // Saturates so a long idle line never wraps into a spurious timeout.
    if (fe) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_MAX) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    unique case (state_q)
      RX_IDLE: begin
        if (fe && !dat_s) begin
          state_d   = RX_SHIFT;
          bit_cnt_d = '0;
        end
      end
      RX_SHIFT: begin
        if (fe) begin
          shift_d   = {dat_s, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = RX_CHECK;
          end
        end else if (idle_cnt_q == TO_MAX) begin
          frame_err_d = 1'b1;
          state_d     = RX_IDLE;
        end
      end
      RX_CHECK: begin
        state_d = RX_IDLE;
        if (frame_ok(shift_q)) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[7:0];
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_events.sv
// PS/2 keyboard front end: frame receiver, make/break/E0 decoder, up/down key
// counter and a first-word-fall-through event FIFO with valid/ready output.
module ps2_key_events
  import ps2_key_events_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  UP_CODE        = 8'h75,
  parameter logic [7:0]  DOWN_CODE      = 8'h72
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic [CNT_WIDTH-1:0]          count,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (CLK),
    .rst       (rst),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_err)
  );

  dec_state_e           dec_q, dec_d;
  logic                 emit;
  evt_t                 evt_new;
  logic                 has_ext, has_brk;

  logic [CNT_WIDTH-1:0] count_q, count_d;
  evt_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 full, pop, push;
  evt_t                 head;

  assign has_ext = (dec_q == D_EXT) || (dec_q == D_EXTBRK);
  assign has_brk = (dec_q == D_BRK) || (dec_q == D_EXTBRK);

  // Emission is combinational on the receiver strobe so the push lands in the
  // same cycle the byte is presented.
  always_comb begin
    dec_d        = dec_q;
    emit         = 1'b0;
    evt_new      = '0;
    evt_new.ext  = has_ext;
    evt_new.brk  = has_brk;
    evt_new.code = rx_byte;
    if (rx_err) begin
      dec_d = D_BASE;
    end else if (rx_valid) begin
      if (rx_byte == PFX_EXT) begin
        dec_d = has_brk ? D_EXTBRK : D_EXT;
      end else if (rx_byte == PFX_BRK) begin
        dec_d = has_ext ? D_EXTBRK : D_BRK;
      end else begin
        emit  = 1'b1;
        dec_d = D_BASE;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (emit && !evt_new.brk) begin
      if (evt_new.code == UP_CODE) begin
        count_d = count_q + 1'b1;
      end else if (evt_new.code == DOWN_CODE) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  assign full = (level_q == LVL_FULL);
  assign pop  = evt_valid && evt_ready;
  assign push = emit && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    level_d    = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (emit && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      dec_q      <= D_BASE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= evt_new;
    end
  end

  assign evt_valid  = (level_q != '0);
  assign head       = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign evt_code   = head.code;
  assign evt_break  = head.brk;
  assign evt_ext    = head.ext;
  assign count      = count_q;
  assign frame_err  = rx_err;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_ps2_key_events.sv
// Bench for ps2_key_events: vector table, directed corner cases and a random
// byte stream scored against a queue-based reference of the decode rules.
module tb_ps2_key_events;

  localparam int HALF    = 15;
  localparam int TIMEOUT = 200;
  localparam int DEPTH   = 8;

  logic       CLK;
  logic       rst;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic [7:0] count;
  logic       frame_err;
  logic       overflow;
  logic [3:0] fifo_level;

  ps2_key_events #(
    .FIFO_DEPTH    (DEPTH),
    .CNT_WIDTH     (8),
    .TIMEOUT_CYCLES(TIMEOUT),
    .UP_CODE       (8'h75),
    .DOWN_CODE     (8'h72)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int err_pulses = 0;
  int err_cyc  = 0;
  int rise_cyc = 0;
  logic [7:0] rise_count, rise_prev_count, prev_count;
  logic prev_valid;

  logic man_ready, rand_ready, rand_mode;
  assign evt_ready = rand_mode ? rand_ready : man_ready;

  logic [9:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (frame_err) begin
      err_pulses <= err_pulses + 1;
      err_cyc    <= cyc;
    end
    prev_valid <= evt_valid;
    prev_count <= count;
    if (evt_valid && !prev_valid) begin
      rise_cyc        <= cyc;
      rise_count      <= count;
      rise_prev_count <= prev_count;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Random-phase consumer: pops at random and scores each popped head.
  always @(negedge CLK) begin
    if (rand_mode) begin
      rand_ready = 1'($urandom_range(0, 1));
      if (rand_ready && evt_valid) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_evt", {22'b0, evt_ext, evt_break, evt_code}, 32'h3FF);
        end else begin
          chk("rand_evt", {22'b0, evt_ext, evt_break, evt_code}, {22'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v, input bit mark, input int pop_off);
    @(negedge CLK);
    PS2_DAT = v;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b0;
    if (mark) fall_cyc = cyc;
    for (int j = 1; j <= HALF; j++) begin
      @(negedge CLK);
      if (pop_off > 0) begin
        if (j == pop_off) begin
          chk("pushpop_head_before", 32'(evt_code), 32'h10);
          man_ready = 1'b1;
        end else begin
          man_ready = 1'b0;
        end
      end
    end
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int pop_off);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i], i == 10, (i == 10) ? pop_off : 0);
    repeat (20) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 0);
  endtask

  task automatic send_partial(input int nbits);
    logic [10:0] bits;
    bits = {1'b1, 1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop_check(input string name, input logic [7:0] code, input logic brk, input logic ext);
    @(negedge CLK);
    chk({name, "_valid"}, 32'(evt_valid), 32'd1);
    chk({name, "_evt"}, {22'b0, evt_ext, evt_break, evt_code}, {22'b0, ext, brk, code});
    man_ready = 1'b1;
    @(negedge CLK);
    man_ready = 1'b0;
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    int         delta;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] bs[4];
    logic [7:0] exp_count, b, m_count;
    logic m_ext, m_brk;
    int e0, err_off, good_off, r;

    vecs[0]  = '{1, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h1C, 1'b0, 1'b0,  0};
    vecs[1]  = '{2, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h1C, 1'b1, 1'b0,  0};
    vecs[2]  = '{2, 8'hE0, 8'h75, 8'h00, 8'h00, 8'h75, 1'b0, 1'b1,  1};
    vecs[3]  = '{3, 8'hE0, 8'hF0, 8'h75, 8'h00, 8'h75, 1'b1, 1'b1,  0};
    vecs[4]  = '{3, 8'hF0, 8'hE0, 8'h72, 8'h00, 8'h72, 1'b1, 1'b1,  0};
    vecs[5]  = '{1, 8'h75, 8'h00, 8'h00, 8'h00, 8'h75, 1'b0, 1'b0,  1};
    vecs[6]  = '{1, 8'h75, 8'h00, 8'h00, 8'h00, 8'h75, 1'b0, 1'b0,  1};
    vecs[7]  = '{3, 8'hE0, 8'hE0, 8'h72, 8'h00, 8'h72, 1'b0, 1'b1, -1};
    vecs[8]  = '{3, 8'hF0, 8'hF0, 8'h75, 8'h00, 8'h75, 1'b1, 1'b0,  0};
    vecs[9]  = '{4, 8'hE0, 8'hF0, 8'hE0, 8'h1C, 8'h1C, 1'b1, 1'b1,  0};
    vecs[10] = '{2, 8'hF0, 8'h72, 8'h00, 8'h00, 8'h72, 1'b1, 1'b0,  0};
    vecs[11] = '{1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0,  0};

    rst = 1'b0; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
    man_ready = 1'b0; rand_ready = 1'b0; rand_mode = 1'b0;
    do_reset();

    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code", 32'(evt_code), 32'd0);
    chk("rst_evt_break", 32'(evt_break), 32'd0);
    chk("rst_evt_ext", 32'(evt_ext), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);

    exp_count = 8'd0;
    for (int v = 0; v < 12; v++) begin
      bs = '{vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3};
      for (int k = 0; k < vecs[v].n; k++) send(bs[k]);
      exp_count = exp_count + 8'(vecs[v].delta);
      @(negedge CLK);
      chk($sformatf("vec%0d_level", v), 32'(fifo_level), 32'd1);
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(exp_count));
      pop_check($sformatf("vec%0d", v), vecs[v].code, vecs[v].brk, vecs[v].ext);
      chk($sformatf("vec%0d_empty", v), 32'(evt_valid), 32'd0);
    end

    // Wrap below zero, then the mixed counter sequence
    do_reset();
    send(8'hE0); send(8'h72);
    chk("wrap_count", 32'(count), 32'hFF);
    pop_check("wrap", 8'h72, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); end
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("cnt_seq_count", 32'(count), 32'd2);
    chk("cnt_seq_level", 32'(fifo_level), 32'd5);
    for (int i = 0; i < 3; i++) pop_check("cnt_up", 8'h75, 1'b0, 1'b1);
    pop_check("cnt_dn", 8'h72, 1'b0, 1'b1);
    pop_check("cnt_brk", 8'h75, 1'b1, 1'b1);

    // Parity error: single pulse, no event; then a good frame one cycle later in the pipe
    do_reset();
    e0 = err_pulses;
    send_frame(8'h75, 1'b1, 0);
    chk("par_err_pulses", 32'(err_pulses - e0), 32'd1);
    err_off = err_cyc - fall_cyc;
    chk("par_level", 32'(fifo_level), 32'd0);
    chk("par_count", 32'(count), 32'd0);
    send(8'hE0); send(8'h75);
    good_off = rise_cyc - fall_cyc;
    chk("par_timing_evt_after_err", 32'(good_off), 32'(err_off + 1));
    chk("par_count_at_rise", 32'(rise_count), 32'd1);
    chk("par_count_before_rise", 32'(rise_prev_count), 32'd0);
    pop_check("par_next", 8'h75, 1'b0, 1'b1);
    chk("par_no_extra_err", 32'(err_pulses - e0), 32'd1);

    // Timeout: pending E0 must be cleared by the error
    e0 = err_pulses;
    send(8'hE0);
    send_partial(5);
    repeat (TIMEOUT + 40) @(negedge CLK);
    chk("to_err_pulses", 32'(err_pulses - e0), 32'd1);
    send(8'h1C);
    pop_check("to_next", 8'h1C, 1'b0, 1'b0);
    chk("to_no_extra_err", 32'(err_pulses - e0), 32'd1);

    // Reset mid-frame
    e0 = err_pulses;
    send_partial(4);
    do_reset();
    send(8'h1C);
    chk("rstmid_no_err", 32'(err_pulses - e0), 32'd0);
    pop_check("rstmid_next", 8'h1C, 1'b0, 1'b0);

    // Full FIFO with overflow
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) send(8'h75);
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_count", 32'(count), 32'(DEPTH + 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("full_head_stable", {22'b0, evt_ext, evt_break, evt_code}, 32'h075);
    end
    for (int i = 0; i < DEPTH; i++) pop_check("full_drain", 8'h75, 1'b0, 1'b0);
    chk("full_drained", 32'(fifo_level), 32'd0);
    chk("full_overflow_sticky", 32'(overflow), 32'd1);

    // Push and pop in the same cycle while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i));
    chk("pp_level_full", 32'(fifo_level), 32'(DEPTH));
    send_frame(8'h10 + 8'(DEPTH), 1'b0, good_off - 1);
    man_ready = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'(DEPTH));
    chk("pp_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= DEPTH; i++) pop_check("pp_order", 8'h10 + 8'(i), 1'b0, 1'b0);
    chk("pp_empty", 32'(evt_valid), 32'd0);

    // Random byte stream against the reference decode rules
    do_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_count = 8'd0;
    e0 = err_pulses;
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4, 5:    b = 8'h75;
        6:       b = 8'h72;
        default: begin
          b = 8'($urandom);
          if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
        end
      endcase
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        exp_q.push_back({m_ext, m_brk, b});
        if (!m_brk && b == 8'h75) m_count = m_count + 8'd1;
        if (!m_brk && b == 8'h72) m_count = m_count - 8'd1;
        m_ext = 1'b0; m_brk = 1'b0;
      end
      send(b);
    end
    repeat (60) @(negedge CLK);
    @(posedge CLK);
    #1 rand_mode = 1'b0;
    @(negedge CLK);
    chk("rand_all_consumed", 32'(exp_q.size()), 32'd0);
    chk("rand_empty", 32'(evt_valid), 32'd0);
    chk("rand_count", 32'(count), 32'(m_count));
    chk("rand_overflow", 32'(overflow), 32'd0);
    chk("rand_no_err", 32'(err_pulses - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_events.md
# ps2_key_events

Parametrised PS/2 keyboard front end: receives PS/2 frames, validates them, and decodes make/break/extended scan-code sequences into key events. Events are buffered in a first-word-fall-through FIFO with a valid/ready handshake. An up/down counter driven by configurable key codes is built in. It sits between the PS/2 pins and game/typing logic, replacing the single-byte `done`/`char` interface with queued, fully decoded events.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, at least 2.
- `CNT_WIDTH`, 8: width of `count`.
- `TIMEOUT_CYCLES`, 50000: CLK cycles without a PS/2 clock edge before a partial frame is discarded.
- `UP_CODE`, 8'h75: scan code that increments `count` on make.
- `DOWN_CODE`, 8'h72: scan code that decrements `count` on make.

- `CLK`  in  1: system clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `PS2_CLK`  in  1: raw PS/2 clock; asynchronous.
- `PS2_DAT`  in  1: raw PS/2 data; asynchronous.
- `evt_valid`  out  1: FIFO head holds an event.
- `evt_ready`  in  1: consumer accepts the head this cycle.
- `evt_code`  out  8: scan code of the head event.
- `evt_break`  out  1: 1 means key release; 0 means press.
- `evt_ext`  out  1: the event was E0-prefixed.
- `count`  out  CNT_WIDTH: up/down key counter.
- `frame_err`  out  1: one-cycle pulse on a bad or timed-out frame.
- `overflow`  out  1: sticky; set when an event is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of occupied entries.

## Operation
- **Input sync:** `PS2_CLK` and `PS2_DAT` each pass through a 2-FF synchronizer. The edge strobe `fe` fires when the synchronized clock was 1 last cycle and is 0 this cycle.
- **Receiver FSM:**
  - RX_IDLE: on `fe` with data 0 (start bit), go to RX_SHIFT and clear the bit counter. A start bit of 1 is ignored with no error.
  - RX_SHIFT: on each `fe`, shift in 8 data bits LSB first, then parity, then stop. After the stop bit, go to RX_CHECK.
  - RX_CHECK (one cycle): the byte is good if the 9 bits {data, parity} have odd parity and stop = 1. Otherwise pulse `frame_err` and drop the byte.
  - Return to RX_IDLE after RX_CHECK.
- **Timeout:** the idle-cycle counter clears on every `fe`. If it reaches TIMEOUT_CYCLES-1 while in RX_SHIFT, pulse `frame_err` and go to RX_IDLE.
- **Decoder FSM** (consumes good bytes):
  - States D_BASE, D_EXT, D_BRK, D_EXTBRK.
  - E0 sets the ext flag; F0 sets the brk flag. Neither prefix byte produces an event.
  - Any other byte emits {code, brk, ext} and returns to D_BASE.
  - Repeated prefixes are idempotent.
  - Any `frame_err` returns the decoder to D_BASE.
- **Counter:**
  - On an emitted event with `evt_break`=0: `count`+1 if code is UP_CODE, `count`-1 if code is DOWN_CODE.
  - `evt_ext` is ignored.
  - Wraps modulo 2^CNT_WIDTH.
  - Updates even when the event is dropped by a full FIFO.
  - Break events never change `count`.
  - Typematic repeats (repeated makes with no break) count each time.
- **FIFO (FWFT):**
  - A pop occurs on `evt_valid && evt_ready`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set.
  - Head outputs are stable while `evt_valid && !evt_ready`.
  - Head fields read 0 when the FIFO is empty.
- **Reset:**
  - All outputs go to 0: `evt_valid`, `evt_code`, `evt_break`, `evt_ext`, `count`, `frame_err`, `overflow`, `fifo_level`.
  - FSMs go to RX_IDLE and D_BASE; the FIFO is emptied and both synchronizers are loaded with 1.
  - Reset asserted mid-frame discards the partial frame with no `frame_err`.

## Timing
- Let E be the cycle in which `fe` fires for the stop bit.
  - RX_CHECK occurs at E+1.
  - The decoder push occurs at E+2.
  - `count` and `fifo_level` change at E+3.
  - `evt_valid` rises at E+3 if the FIFO was empty.
- A raw `PS2_CLK` fall appears as `fe` 3 cycles later.
- `frame_err` for a parity/stop error is high at E+2 only. For a timeout it is high for exactly one cycle.
- Throughput: at most one event per PS/2 frame (roughly 1 per 1000+ CLK cycles), so decode needs no stall.

## Structure
- Shared package holds: prefix constants (8'hE0, 8'hF0), state encodings, and an event struct {ext, brk, code[7:0]}, which is 10 bits wide.
- One sub-module, `ps2_frame_rx`: synchronizers, edge detect, receiver FSM and timeout. It outputs a byte with a valid strobe and `frame_err`.
- The decoder, counter and FIFO live in the top level.

## Test plan
- **Make/break:** frames 0x1C, F0, 1C with `evt_ready`=1 -> events {1C,brk0,ext0} then {1C,brk1,ext0}; `count` stays 0.
- **Counter:** E0 75 sent three times, E0 72 once, E0 F0 75 once -> `count`=2, all events ext=1. From reset, a single E0 72 -> `count`=2^CNT_WIDTH-1 (wrap).
- **Parity error:** frame 0x75 with even parity -> `frame_err` one-cycle pulse at E+2, no event, `count` unchanged. A following good E0 75 decodes normally.
- **Timeout and reset:** send 5 bits then idle TIMEOUT_CYCLES -> one `frame_err`, back to RX_IDLE. Separately, assert `rst` after 4 bits -> no error, next frame decodes.
- **Full FIFO:** hold `evt_ready`=0 and send FIFO_DEPTH+1 makes of 0x75 -> `fifo_level`=FIFO_DEPTH, `overflow`=1, `count`=FIFO_DEPTH+1. The head stays the first event until released, then the FIFO drains in order.
- **Push/pop on full:** with the FIFO full, pop in the same cycle as a push -> push accepted, `fifo_level` unchanged, `overflow` not set.
